nic_core: RTL

Parametrised successor to the nic8 single-cycle datapath top. Replaces the tri-state data bus with a multiplexed internal bus, generalises datapath width, and sequences each instruction through a small fetch/decode/execute FSM. Data memory sits behind a req/ack handshake so slow or shared memory can insert wait states. Sits between a synchronous program ROM and an external data-memory port; drives the Q output register.

---
 rtl/nic_pkg.sv | 80 ++++++++
 rtl/nic_alu.sv | 30 +++
 rtl/nic_core.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/nic_pkg.sv
// nic_pkg: shared definitions for the nic_core datapath.
//   - FSM state encoding
//   - source / destination / jump-condition encodings of the opcode fields
//   - opcode field positions and the HALT opcode constant
//   - small helpers that pull fields out of an 8-bit opcode and decide
//     whether an instruction needs the data-memory port
package nic_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SRC_M = 2'd0,   // memory (imm=0) or immediate byte (imm=1)
        SRC_E = 2'd1,   // ALU result
        SRC_A = 2'd2,
        SRC_X = 2'd3
    } src_e;

    typedef enum logic [2:0] {
        DST_NOP  = 3'd0,
        DST_PC   = 3'd1,
        DST_A    = 3'd2,
        DST_B    = 3'd3,
        DST_X    = 3'd4,
        DST_Q    = 3'd5,
        DST_M    = 3'd6,
        DST_NONE = 3'd7
    } dst_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'd0,
        COND_AZERO  = 2'd1,
        COND_CARRY  = 2'd2,
        COND_NEVER  = 2'd3
    } cond_e;

    // Opcode layout: {src[1:0], dst[2:0], imm, c[1:0]}
    localparam int SRC_LSB = 6;
    localparam int DST_LSB = 3;
    localparam int IMM_BIT = 2;
    localparam int C_LSB   = 0;

    localparam logic [7:0] HALT_OP = 8'hFF;

    function automatic src_e op_src(input logic [7:0] op);
        return src_e'(op[SRC_LSB +: 2]);
    endfunction

    function automatic dst_e op_dst(input logic [7:0] op);
        return dst_e'(op[DST_LSB +: 3]);
    endfunction

    function automatic logic op_imm(input logic [7:0] op);
        return op[IMM_BIT];
    endfunction

    function automatic cond_e op_cond(input logic [7:0] op);
        return cond_e'(op[C_LSB +: 2]);
    endfunction

    // True when the instruction reads or writes data memory.
    // M->M (memory source into memory destination) is a no-op and
    // issues nothing; a memory read into the reserved destination
    // is likewise suppressed.
    function automatic logic needs_mem(input logic [7:0] op);
        logic mem_src;
        logic rd;
        logic wr;
        mem_src = (op_src(op) == SRC_M) && !op_imm(op);
        rd      = mem_src && (op_dst(op) != DST_M) && (op_dst(op) != DST_NOP);
        wr      = !mem_src && (op_dst(op) == DST_M);
        return rd || wr;
    endfunction

endpackage

// File: rtl/nic_alu.sv
// nic_alu: W-bit adder/subtractor for nic_core.
// Ports:
//   a, b    in  W  operands (A and B registers)
//   sub     in  1  1 = a + ~b + 1, 0 = a + b
//   y       out W  result
//   carry   out 1  carry-out of bit W-1
//   a_zero  out 1  operand a is zero (used by the A==0 jump condition)
module nic_alu #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         carry,
    output logic         a_zero
);

    logic [W-1:0] b_op;
    logic [W:0]   sum;

    assign b_op   = sub ? ~b : b;
    // Subtract is add of the inverted operand with carry-in 1, so the
    // carry flag reads as "no borrow" after a subtraction.
    assign sum    = {1'b0, a} + {1'b0, b_op} + {{W{1'b0}}, sub};
    assign y      = sum[W-1:0];
    assign carry  = sum[W];
    assign a_zero = (a == '0);

endmodule

// File: rtl/nic_core.sv
// nic_core: multi-cycle accumulator core with a multiplexed internal bus.
// Each instruction runs FETCH -> DECODE -> EXEC (3 cycles) or
// FETCH -> DECODE -> MEM (3 + wait cycles) when data memory is involved.
//
// Optional feature macro: NIC_CORE_HALT_EN
//   defined   : opcode 0xFF parks the core in HALT until reset
//   undefined : 0xFF is an ordinary 3-cycle no-op, halted stays 0
//
// Ports:
//   clk, reset   in   clock, synchronous active-high reset
//   prog_addr    out W program ROM address (combinational)
//   prog_rdata   in  W ROM data, one cycle after prog_addr
//   dmem_req     out 1 data-memory request, held until dmem_ack
//   dmem_we      out 1 1 = write, 0 = read
//   dmem_addr    out W X register while requesting, else 0
//   dmem_wdata   out W write data while writing, else 0
//   dmem_rdata   in  W read data, taken in the ack cycle
//   dmem_ack     in  1 completes the request in the same cycle
//   qreg         out W output register
//   q_valid      out 1 one-cycle pulse after each Q write
//   halted       out 1 core stopped on HALT opcode
module nic_core
    import nic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    output logic [W-1:0] prog_addr,
    input  logic [W-1:0] prog_rdata,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [W-1:0] dmem_addr,
    output logic [W-1:0] dmem_wdata,
    input  logic [W-1:0] dmem_rdata,
    input  logic         dmem_ack,
    output logic [W-1:0] qreg,
    output logic         q_valid,
    output logic         halted
);

    localparam logic [W-1:0] ONE = W'(1);

    state_e       state;
    logic [W-1:0] pc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] x;
    logic [7:0]   ir;
    logic         carry;

    src_e         src;
    dst_e         dst;
    logic         imm;
    cond_e        cond;

    logic [W-1:0] alu_y;
    logic         alu_carry;
    logic         alu_sub;
    logic         a_zero;

    logic [W-1:0] bus;
    logic         take;
    logic         writes_dst;
    logic         mem_done;
    logic         commit;

    assign src  = op_src(ir);
    assign dst  = op_dst(ir);
    assign imm  = op_imm(ir);
    assign cond = op_cond(ir);

    // For jumps the c field is a condition, not an ALU mode.
    assign alu_sub = ir[C_LSB] && (dst != DST_PC);

    nic_alu #(.W(W)) u_alu (
        .a      (a),
        .b      (b),
        .sub    (alu_sub),
        .y      (alu_y),
        .carry  (alu_carry),
        .a_zero (a_zero)
    );

    // Internal bus: one source drives it per instruction.
    always_comb begin
        bus = '0;
        case (src)
            SRC_M:   bus = imm ? prog_rdata : dmem_rdata;
            SRC_E:   bus = alu_y;
            SRC_A:   bus = a;
            SRC_X:   bus = x;
            default: bus = '0;
        endcase
    end

    // Jump conditions see A and carry as left by the previous instruction.
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_ALWAYS: take = 1'b1;
            COND_AZERO:  take = a_zero;
            COND_CARRY:  take = carry;
            COND_NEVER:  take = 1'b0;
            default:     take = 1'b0;
        endcase
    end

    always_comb begin
        writes_dst = 1'b0;
        case (dst)
            DST_PC:  writes_dst = take;
            DST_A,
            DST_B,
            DST_X,
            DST_Q,
            DST_M:   writes_dst = 1'b1;
            default: writes_dst = 1'b0;
        endcase
    end

    assign mem_done = (state == ST_MEM) && dmem_req && dmem_ack;
    assign commit   = (state == ST_EXEC) || mem_done;

    // In DECODE the ROM is already asked for the byte after the opcode so
    // an immediate is on prog_rdata in EXEC/MEM; later states hold PC so
    // that byte stays put through memory wait states.
    always_comb begin
        prog_addr = pc;
        if (state == ST_DECODE) prog_addr = pc + ONE;
    end

    // Address and data are qualified by the registered request so they
    // read 0 outside a transaction and cannot move while req is high.
    assign dmem_addr  = dmem_req ? x : '0;
    assign dmem_wdata = (dmem_req && dmem_we) ? bus : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_FETCH;
            pc       <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            x        <= '0;
            qreg     <= '0;
            carry    <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            q_valid  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            q_valid <= 1'b0;

            case (state)
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir <= prog_rdata[7:0];
                    pc <= pc + ONE;
`ifdef NIC_CORE_HALT_EN
                    if (prog_rdata[7:0] == HALT_OP) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else
`endif
                    if (needs_mem(prog_rdata[7:0])) begin
                        state    <= ST_MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= (op_dst(prog_rdata[7:0]) == DST_M);
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        state    <= ST_FETCH;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase

            if (commit) begin
                // Immediate byte is consumed whether or not a jump is taken;
                // a taken jump below overrides this PC update.
                if (src == SRC_M && imm) pc <= pc + ONE;

                case (dst)
                    DST_PC: if (take) pc <= bus;
                    DST_A:  a <= bus;
                    DST_B:  b <= bus;
                    DST_X:  x <= bus;
                    DST_Q: begin
                        qreg    <= bus;
                        q_valid <= 1'b1;
                    end
                    default: ;
                endcase

                if (src == SRC_E && writes_dst) carry <= alu_carry;
            end
        end
    end

endmodule
